// File: rtl/hazard_ctrl.sv
// hazard_ctrl: tracks in-flight destination registers of the post-decode stages
// and derives operand forwarding selects, load-use stalls with bubble insertion,
// branch flushes and bus wait-state freezes for the pipelined cpu_core.
// Optional feature macro: HAZARD_PERF_CNT_EN adds perf_stall_cnt / perf_flush_cnt.
module hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_we,
    input  logic              id_is_load,
    input  logic              ex_branch_taken,
    input  logic              bus_ready,
    output logic              stall_if,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic              flush_if,
    output logic              flush_id,
    output logic              freeze,
    output logic [SEL_W-1:0]  fwd_rs1_sel,
    output logic [SEL_W-1:0]  fwd_rs2_sel
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              load;
    } sb_entry_t;

    // Index 0 is the instruction now in EX, DEPTH-1 the one in WB.
    sb_entry_t sb_reg [DEPTH];

    logic             frozen;
    logic             rs1_live;
    logic             rs2_live;
    logic [DEPTH-1:0] match_rs1;
    logic [DEPTH-1:0] match_rs2;
    logic [SEL_W-1:0] sel_rs1;
    logic [SEL_W-1:0] sel_rs2;
    logic             haz_rs1;
    logic             haz_rs2;
    logic             load_use;

    assign frozen = !bus_ready;

    // x0 is hard-wired zero, so a source of x0 never depends on anything.
    assign rs1_live = id_valid && id_rs1_used && (id_rs1 != '0);
    assign rs2_live = id_valid && id_rs2_used && (id_rs2 != '0);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match_rs1[gi] = rs1_live && sb_reg[gi].valid && sb_reg[gi].we
                                   && (sb_reg[gi].rd == id_rs1);
            assign match_rs2[gi] = rs2_live && sb_reg[gi].valid && sb_reg[gi].we
                                   && (sb_reg[gi].rd == id_rs2);
        end
    endgenerate

    // Youngest-match search: scanning oldest to youngest lets the lowest index win.
    always_comb begin
        sel_rs1 = '0;
        sel_rs2 = '0;
        haz_rs1 = 1'b0;
        haz_rs2 = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match_rs1[k]) begin
                sel_rs1 = SEL_W'(k + 1);
                haz_rs1 = sb_reg[k].load && (k < LOAD_LAT);
            end
            if (match_rs2[k]) begin
                sel_rs2 = SEL_W'(k + 1);
                haz_rs2 = sb_reg[k].load && (k < LOAD_LAT);
            end
        end
    end

    assign load_use = haz_rs1 || haz_rs2;

    // freeze tracks the bus directly, even while reset is held.
    assign freeze = frozen;

    // Control decode: freeze beats branch flush beats load-use stall.
    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        bubble_ex   = 1'b0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        fwd_rs1_sel = '0;
        fwd_rs2_sel = '0;
        if (!rst) begin
            // Data not ready yet during a load-use hazard, so the mux is parked on 0.
            fwd_rs1_sel = load_use ? '0 : sel_rs1;
            fwd_rs2_sel = load_use ? '0 : sel_rs2;
            if (frozen) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
            end else if (ex_branch_taken) begin
                // The ID instruction is on the wrong path; any stall it wanted is moot.
                flush_if = 1'b1;
                flush_id = 1'b1;
            end else if (load_use) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
        end
    end

    // Scoreboard shift: advances with the pipeline, holds while frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_reg[k] <= '0;
            end
        end else if (!frozen) begin
            sb_reg[0].valid <= id_valid && !bubble_ex && !flush_id;
            sb_reg[0].rd    <= id_rd;
            sb_reg[0].we    <= id_reg_we;
            sb_reg[0].load  <= id_is_load;
            for (int k = 1; k < DEPTH; k++) begin
                sb_reg[k] <= sb_reg[k-1];
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;

    // Event counters; bubble_ex and flush_id are already low while frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (bubble_ex) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (flush_id) begin
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_reg;
    assign perf_flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table, reset-mid-stall sequence and random
// stimulus checked against a queue-based pipeline model of hazard_ctrl.
`timescale 1ns/1ps
module tb_hazard_ctrl;
    localparam int REG_AW   = 5;
    localparam int DEPTH    = 3;
    localparam int LOAD_LAT = 1;
    localparam int SEL_W    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              id_rs1_used, id_rs2_used;
    logic              id_reg_we, id_is_load;
    logic              ex_branch_taken, bus_ready;
    logic              stall_if, stall_id, bubble_ex, flush_if, flush_id, freeze;
    logic [SEL_W-1:0]  fwd_rs1_sel, fwd_rs2_sel;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]       perf_stall_cnt, perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_we(id_reg_we), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken), .bus_ready(bus_ready),
        .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .flush_if(flush_if), .flush_id(flush_id), .freeze(freeze),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    // ctl bit order: {stall_if, stall_id, bubble_ex, flush_if, flush_id, freeze}
    typedef struct {
        string             name;
        logic              v;
        logic [REG_AW-1:0] rs1, rs2;
        logic              u1, u2;
        logic [REG_AW-1:0] rd;
        logic              we, ld, br, rdy;
        logic [5:0]        ctl;
        logic [SEL_W-1:0]  f1, f2;
    } vec_t;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              ld;
    } ent_t;

    ent_t        pipe[$];      // pipe[0] = instruction in EX
    int unsigned m_stall_cnt, m_flush_cnt;
    int          vectors     = 0;
    int          miscompares = 0;
    vec_t        tbl[$];

    function automatic vec_t mkv(string name, logic v, int rs1, int rs2, logic u1, logic u2,
                                 int rd, logic we, logic ld, logic br, logic rdy,
                                 logic [5:0] ctl, int f1, int f2);
        vec_t t;
        t.name = name; t.v = v; t.rs1 = REG_AW'(rs1); t.rs2 = REG_AW'(rs2);
        t.u1 = u1; t.u2 = u2; t.rd = REG_AW'(rd); t.we = we; t.ld = ld;
        t.br = br; t.rdy = rdy; t.ctl = ctl; t.f1 = SEL_W'(f1); t.f2 = SEL_W'(f2);
        return t;
    endfunction

    task automatic model_reset();
        pipe = {};
        for (int i = 0; i < DEPTH; i++) pipe.push_back('0);
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    // Where does this source come from: stage k+1 of the youngest writer, or the RF.
    function automatic void src_lookup(input logic used, input logic [REG_AW-1:0] rs,
                                       output logic [SEL_W-1:0] sel, output logic haz);
        sel = '0;
        haz = 1'b0;
        if (!(id_valid && used && rs != 0)) return;
        for (int k = 0; k < DEPTH; k++) begin
            if (pipe[k].v && pipe[k].we && pipe[k].rd == rs) begin
                sel = SEL_W'(k + 1);
                haz = pipe[k].ld && (k < LOAD_LAT);
                return;
            end
        end
    endfunction

    function automatic logic model_hazard();
        logic [SEL_W-1:0] s1, s2;
        logic h1, h2;
        src_lookup(id_rs1_used, id_rs1, s1, h1);
        src_lookup(id_rs2_used, id_rs2, s2, h2);
        return h1 || h2;
    endfunction

    task automatic model_expect(output logic [5:0] ctl, output logic [SEL_W-1:0] f1,
                                output logic [SEL_W-1:0] f2);
        logic [SEL_W-1:0] s1, s2;
        logic h1, h2, haz;
        src_lookup(id_rs1_used, id_rs1, s1, h1);
        src_lookup(id_rs2_used, id_rs2, s2, h2);
        haz = h1 || h2;
        f1 = haz ? '0 : s1;
        f2 = haz ? '0 : s2;
        if (rst) begin
            ctl = {5'b00000, !bus_ready};
            f1 = '0;
            f2 = '0;
        end else if (!bus_ready)   ctl = 6'b110001;
        else if (ex_branch_taken)  ctl = 6'b000110;
        else if (haz)              ctl = 6'b111000;
        else                       ctl = 6'b000000;
    endtask

    // Pipeline moves one stage unless frozen or in reset.
    task automatic model_advance();
        ent_t e;
        logic haz;
        if (rst || !bus_ready) return;
        haz  = model_hazard();
        e.v  = id_valid && !ex_branch_taken && !haz;
        e.rd = id_rd;
        e.we = id_reg_we;
        e.ld = id_is_load;
        if (ex_branch_taken) m_flush_cnt++;
        else if (haz)        m_stall_cnt++;
        pipe.push_front(e);
        pipe.delete(DEPTH);
    endtask

    task automatic set_in(logic v, logic [REG_AW-1:0] rs1, logic [REG_AW-1:0] rs2,
                          logic u1, logic u2, logic [REG_AW-1:0] rd,
                          logic we, logic ld, logic br, logic rdy);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        id_rd = rd; id_reg_we = we; id_is_load = ld; ex_branch_taken = br; bus_ready = rdy;
    endtask

    task automatic compare(string name, logic [5:0] ectl, logic [SEL_W-1:0] ef1,
                           logic [SEL_W-1:0] ef2);
        logic [5:0] gctl;
        gctl = {stall_if, stall_id, bubble_ex, flush_if, flush_id, freeze};
        vectors++;
        if (gctl !== ectl || fwd_rs1_sel !== ef1 || fwd_rs2_sel !== ef2) begin
            miscompares++;
            $display("FAIL %s: got ctl=%b fwd=%0d/%0d, required ctl=%b fwd=%0d/%0d",
                     name, gctl, fwd_rs1_sel, fwd_rs2_sel, ectl, ef1, ef2);
        end else begin
            $display("ok   %s: ctl=%b fwd=%0d/%0d", name, gctl, fwd_rs1_sel, fwd_rs2_sel);
        end
    endtask

    task automatic compare32(string name, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end else begin
            $display("ok   %s: %0d", name, got);
        end
    endtask

    task automatic model_check(string name);
        logic [5:0] ectl;
        logic [SEL_W-1:0] ef1, ef2;
        model_expect(ectl, ef1, ef2);
        compare(name, ectl, ef1, ef2);
    endtask

    task automatic next_cycle();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        model_reset();

        // Directed table: name, v, rs1, rs2, u1, u2, rd, we, ld, br, rdy, ctl, f1, f2
        tbl.push_back(mkv("addi_x5",    1, 0, 0, 1, 0, 5, 1, 0, 0, 1, 6'b000000, 0, 0));
        tbl.push_back(mkv("add_fwd",    1, 5, 5, 1, 1, 6, 1, 0, 0, 1, 6'b000000, 1, 1));
        tbl.push_back(mkv("lw_x7",      1, 5, 0, 1, 0, 7, 1, 1, 0, 1, 6'b000000, 2, 0));
        tbl.push_back(mkv("sw_stall",   1, 6, 7, 1, 1, 0, 0, 0, 0, 1, 6'b111000, 0, 0));
        tbl.push_back(mkv("sw_fwd",     1, 6, 7, 1, 1, 0, 0, 0, 0, 1, 6'b000000, 3, 2));
        tbl.push_back(mkv("x0_wr_a",    1, 0, 0, 1, 1, 0, 1, 1, 0, 1, 6'b000000, 0, 0));
        tbl.push_back(mkv("x0_wr_b",    1, 0, 0, 1, 1, 0, 1, 1, 0, 1, 6'b000000, 0, 0));
        tbl.push_back(mkv("x0_wr_c",    1, 0, 0, 1, 1, 0, 1, 1, 0, 1, 6'b000000, 0, 0));
        tbl.push_back(mkv("x0_read",    1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 6'b000000, 0, 0));
        tbl.push_back(mkv("lw_x9",      1, 0, 0, 1, 0, 9, 1, 1, 0, 1, 6'b000000, 0, 0));
        tbl.push_back(mkv("luse_br",    1, 9, 0, 1, 0, 11, 1, 0, 1, 1, 6'b000110, 0, 0));
        tbl.push_back(mkv("post_br",    1, 9, 11, 1, 1, 10, 1, 0, 0, 1, 6'b000000, 2, 0));
        tbl.push_back(mkv("frz_br_1",   1, 10, 0, 1, 0, 12, 1, 0, 1, 0, 6'b110001, 1, 0));
        tbl.push_back(mkv("frz_br_2",   1, 10, 0, 1, 0, 12, 1, 0, 1, 0, 6'b110001, 1, 0));
        tbl.push_back(mkv("frz_br_3",   1, 10, 0, 1, 0, 12, 1, 0, 1, 0, 6'b110001, 1, 0));
        tbl.push_back(mkv("br_release", 1, 10, 0, 1, 0, 12, 1, 0, 1, 1, 6'b000110, 1, 0));
        tbl.push_back(mkv("sb_held",    1, 10, 9, 1, 1, 0, 0, 0, 0, 1, 6'b000000, 2, 0));

        // Reset state, including freeze following the bus during reset.
        #3;
        compare("reset_state", 6'b000000, '0, '0);
        bus_ready = 1'b0;
        #1;
        compare("reset_freeze", 6'b000001, '0, '0);
        bus_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            set_in(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2,
                   tbl[i].rd, tbl[i].we, tbl[i].ld, tbl[i].br, tbl[i].rdy);
            #1;
            compare(tbl[i].name, tbl[i].ctl, tbl[i].f1, tbl[i].f2);
            next_cycle();
        end

        // Reset asserted in the middle of a load-use stall.
        set_in(1, 0, 0, 0, 0, 7, 1, 1, 0, 1);
        #1;
        model_check("lw_x7_again");
        next_cycle();
        set_in(1, 0, 7, 0, 1, 0, 0, 0, 0, 1);
        #1;
        compare("stall_pre_rst", 6'b111000, '0, '0);
        rst = 1'b1;
        #1;
        compare("rst_mid_stall", 6'b000000, '0, '0);
`ifdef HAZARD_PERF_CNT_EN
        compare32("rst_stall_cnt", perf_stall_cnt, 32'd0);
        compare32("rst_flush_cnt", perf_flush_cnt, 32'd0);
`endif
        bus_ready = 1'b0;
        #1;
        compare("rst_bus_wait", 6'b000001, '0, '0);
        bus_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        compare("post_rst_clear", 6'b000000, '0, '0);
        next_cycle();

        // Random traffic over a small register set so dependencies are frequent.
        for (int n = 0; n < 250; n++) begin
            set_in($urandom_range(0, 6) != 0,
                   REG_AW'($urandom_range(0, 3)), REG_AW'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   REG_AW'($urandom_range(0, 3)),
                   $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 7) == 0, $urandom_range(0, 9) != 0);
            #1;
            model_check($sformatf("rand_%0d", n));
            next_cycle();
        end

`ifdef HAZARD_PERF_CNT_EN
        compare32("stall_cnt", perf_stall_cnt, m_stall_cnt);
        compare32("flush_cnt", perf_flush_cnt, m_flush_cnt);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard and forwarding controller for the pipelined `cpu_core`. It lets the core run back-to-back dependent instructions without software NOPs. It tracks in-flight destination registers through a configurable number of post-decode stages and drives three kinds of control:
- forwarding mux selects for the ID/EX operands;
- load-use stalls with bubble insertion;
- branch flushes and global bus wait-state freezes.

It sits beside the pipeline stages: it reads the decoded instruction in ID, and its outputs feed the stage-register enables and clears.

## Interface
Parameters:
- `REG_AW`, default 5: register address width.
- `DEPTH`, default 3: tracked post-ID stages. Index 0 = EX, 1 = MEM, DEPTH-1 = WB.
- `LOAD_LAT`, default 1: lowest stage index at which load data is forwardable. Range 1..DEPTH-1.
- `SEL_W`, default `$clog2(DEPTH+1)`: forwarding select width.

Ports (clock and reset first):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs1`, `id_rs2`  in  REG_AW  source registers.
- `id_rs1_used`, `id_rs2_used`  in  1  the source is actually read.
- `id_rd`  in  REG_AW  destination register.
- `id_reg_we`  in  1  the instruction writes `rd`.
- `id_is_load`  in  1  the write-back source is memory.
- `ex_branch_taken`  in  1  EX redirects the PC this cycle.
- `bus_ready`  in  1  memory access completes this cycle. Low = wait state.
- `stall_if`, `stall_id`  out  1  hold the PC and the IF/ID register.
- `bubble_ex`  out  1  load an invalid/NOP entry into ID/EX.
- `flush_if`, `flush_id`  out  1  invalidate the IF/ID and ID/EX contents.
- `freeze`  out  1  hold every pipeline register (bus wait).
- `fwd_rs1_sel`, `fwd_rs2_sel`  out  SEL_W  0 = register file, k+1 = result of stage k.

## Operation
Scoreboard:
- `DEPTH` entries, each {valid, rd, we, load}.
- On each advancing edge: entry[0] ← the ID instruction, or invalid if bubbled, flushed or `!id_valid`. Entry[k] ← entry[k-1].
- The oldest entry falls off the end.

Source match for rsN:
- Match condition: the source is used, rsN ≠ 0, entry valid, we=1, rd=rsN.
- The youngest matching entry (lowest k) wins.
- `fwd_rsN_sel` = k+1 for the youngest match, else 0.

Load-use hazard: the youngest match is a load with k < LOAD_LAT. Actions:
- `stall_if` = `stall_id` = `bubble_ex` = 1.
- `fwd_rsN_sel` is don't-care (driven 0).
- The hazard re-evaluates each cycle, so stall length = LOAD_LAT − k cycles.

Branch (`ex_branch_taken`, pipeline not frozen):
- `flush_if` = `flush_id` = 1.
- entry[0] ← invalid.
- Any load-use stall is suppressed that cycle, since the ID instruction is dead.

Freeze (`bus_ready` = 0):
- `freeze` = `stall_if` = `stall_id` = 1; `bubble_ex`, `flush_*` = 0.
- The scoreboard holds.
- A taken branch is deferred: EX holds it, so it asserts again once `bus_ready` = 1.

Priority: freeze > branch flush > load-use stall > normal advance.

## Timing
- All outputs are combinational from the registered scoreboard and the current ID/EX/bus inputs. Zero-cycle decision.
- The scoreboard updates on the `clk` rising edge only when `freeze` = 0.
- Reset (asynchronous, any time, including mid-stall):
  - all entries invalid;
  - all outputs 0: fwd selects 0, no stall, no flush, no bubble.
  - Exception: `freeze` follows `bus_ready` combinationally even during reset.
- Back-to-back dependent ALU instructions: 0 stall cycles, fwd_sel = 1.
- Load followed by a dependent instruction, LOAD_LAT = 1: exactly 1 bubble, then fwd_sel = 2.
- x0 never matches and never stalls.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: adds outputs `perf_stall_cnt[31:0]` and `perf_flush_cnt[31:0]`.
  - `perf_stall_cnt`: +1 per load-use bubble cycle.
  - `perf_flush_cnt`: +1 per cycle with `flush_id` = 1.
  - Both wrap modulo 2^32, reset to 0, and do not count while `freeze` = 1.
- Undefined: the ports and the counters are absent. All other behaviour is identical.

## Test plan
- `addi x5`; next `add x6,x5,x5` → `fwd_rs1_sel` = `fwd_rs2_sel` = 1, no stall.
- `lw x7`; next `sw` using x7 as rs2 (LOAD_LAT=1) → one cycle with `stall_if`/`stall_id`/`bubble_ex` = 1, then `fwd_rs2_sel` = 2.
- Writes to x0 in all stages; ID reads x0 → fwd selects 0, no stall.
- Load-use hazard coincident with `ex_branch_taken` = 1 → `flush_if`/`flush_id` = 1, `bubble_ex` = 0, entry[0] invalid next cycle.
- `bus_ready` low for 3 cycles with a branch in EX → `freeze` = 1 for 3 cycles, scoreboard unchanged, flush asserted on the 4th cycle.
- Assert `rst` mid load-use stall → all outputs 0 immediately; with `HAZARD_PERF_CNT_EN`, both counters read 0.
